mix_columns_seq: RTL and testbench

Sequential AES MixColumns stage that consumes the 128-bit state produced by the SubBytes/ShiftRows datapath. It transforms one 32-bit column per clock. A per-block mode bit selects forward MixColumns for encryption or InvMixColumns for decryption, and a bypass bit passes the state through unchanged for the final round. Blocks move in and out over valid/ready handshakes, so the stage can sit between the combinational byte-substitution logic and the AddRoundKey register of the round controller.

---
 rtl/mix_columns_seq.sv | 116 +++++++++++
 tb/tb_mix_columns_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns stage that transforms one 32-bit column per clock.
// Blocks enter and leave over valid/ready handshakes; a bypass block goes straight to DONE.
//
// state | meaning
// IDLE  | empty, ready for a block
// BUSY  | transforming column col_q of the working register
// DONE  | result held on out_state until the consumer takes it
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic         in_inv,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [0:127] work_q;
  logic [1:0]   col_q;
  logic         inv_q;
  logic         accept;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Each byte contributes four products (row-diagonal, +1, +2, +3); the mode
  // only changes which xtime combinations those products are.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] p  [4];
    logic [7:0] q  [4];
    logic [7:0] s  [4];
    logic [7:0] t  [4];
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      p[i]  = inv ? (x8[i] ^ x4[i] ^ x2[i]) : x2[i];
      q[i]  = inv ? (x8[i] ^ x2[i] ^ a[i])  : (x2[i] ^ a[i]);
      s[i]  = inv ? (x8[i] ^ x4[i] ^ a[i])  : a[i];
      t[i]  = inv ? (x8[i] ^ a[i])          : a[i];
    end
    return {p[0] ^ q[1] ^ s[2] ^ t[3],
            p[1] ^ q[2] ^ s[3] ^ t[0],
            p[2] ^ q[3] ^ s[0] ^ t[1],
            p[3] ^ q[0] ^ s[1] ^ t[2]};
  endfunction

  assign accept    = in_valid && in_ready;
  assign col_in    = work_q[{col_q, 5'b0} +: 32];
  assign col_out   = mix_col(col_in, inv_q);
  assign out_state = work_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = in_last ? DONE : BUSY;
      BUSY: if (col_q == 2'd3) state_d = DONE;
      DONE: begin
        // a block leaving and a new one arriving on the same edge: new block wins
        if (accept)         state_d = in_last ? DONE : BUSY;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = rst_n;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = rst_n && out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      col_q  <= '0;
      inv_q  <= 1'b0;
    end else if (accept) begin
      work_q <= in_state;
      inv_q  <= in_inv;
      col_q  <= '0;
    end else if (state_q == BUSY) begin
      work_q[{col_q, 5'b0} +: 32] <= col_out;
      col_q <= col_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: driver pushes reference results on accept,
// a negedge monitor pops and compares every handed-off block.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] in_state = '0;
  logic         in_inv = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:127] out_state;

  int           n_checks = 0;
  int           n_errors = 0;
  bit           rand_rdy = 1'b0;
  logic [0:127] exp_q[$];
  logic [0:127] mon_exp;

  localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] COL_IN   = 128'hdb135345f20a225cc6c6c6c62d26314c;
  localparam logic [0:127] COL_OUT  = 128'h8e4da1bc9fdc589dc6c6c6c64d7ebdf8;

  mix_columns_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_inv(in_inv), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
  );

  always #5 clk = ~clk;

  // Reference: generic shift-and-add GF(2^8) multiply and a circulant matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [0:127] ref_mix(input logic [0:127] s, input logic inv, input logic last);
    logic [7:0]   row0 [4];
    logic [7:0]   acc;
    logic [0:127] o;
    if (last) return s;
    if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(row0[(j - r + 4) % 4], s[8*(4*c+j) +: 8]);
        o[8*(4*c+r) +: 8] = acc;
      end
    return o;
  endfunction

  task automatic check_vec(input string name, input logic [0:127] act, input logic [0:127] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [0:127] s, input logic inv, input logic last,
                      input logic [0:127] exp, output int waits);
    in_state = s;
    in_inv   = inv;
    in_last  = last;
    in_valid = 1'b1;
    waits    = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready || waits >= 300) break;
      @(posedge clk); #1;
      waits++;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept within 300 cycles");
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_int("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h expected no output", out_state);
      end else begin
        mon_exp = exp_q.pop_front();
        check_vec("out_state", out_state, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w;
    int           n;
    logic [0:127] s;
    logic         inv, last;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_in_ready", int'(in_ready), 0);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_vec("rst_out_state", out_state, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_int("idle_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // FIPS forward with latency; mode bits toggled by send() while BUSY
    send(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, w);
    in_inv = 1'b1;
    in_last = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    check_int("latency", n, 4);
    @(posedge clk); #1;

    send(FIPS_OUT, 1'b1, 1'b0, FIPS_IN, w);
    send(COL_IN, 1'b0, 1'b0, COL_OUT, w);
    send(COL_OUT, 1'b1, 1'b0, COL_IN, w);
    send(COL_IN, 1'b1, 1'b1, COL_IN, w);

    // normal throughput: one block per 5 cycles
    for (int i = 0; i < 3; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      send(s, 1'(i), 1'b0, ref_mix(s, 1'(i), 1'b0), w);
      if (i > 0) check_int("normal_waits", w, 4);
    end

    // bypass throughput: one block per cycle
    for (int i = 0; i < 4; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      send(s, 1'($urandom), 1'b1, s, w);
      if (i > 0) check_int("bypass_waits", w, 0);
    end
    wait_drain();

    // backpressure
    out_ready = 1'b0;
    send(COL_IN, 1'b0, 1'b0, COL_OUT, w);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_state = FIPS_OUT;
    in_inv   = 1'b1;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_int("stall_out_valid", int'(out_valid), 1);
      check_int("stall_in_ready", int'(in_ready), 0);
      check_vec("stall_out_state", out_state, COL_OUT);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(FIPS_OUT, 1'b1, 1'b0, FIPS_IN, w);
    check_int("release_same_edge", w, 0);
    wait_drain();

    // reset while BUSY with col=2
    s = {$urandom, $urandom, $urandom, $urandom};
    send(s, 1'b0, 1'b0, ref_mix(s, 1'b0, 1'b0), w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_int("midrst_out_valid", int'(out_valid), 0);
    check_vec("midrst_out_state", out_state, '0);
    check_int("midrst_idle", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_int("midrst_no_output", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, w);
    wait_drain();

    // random blocks with random backpressure and gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s    = {$urandom, $urandom, $urandom, $urandom};
      inv  = 1'($urandom);
      last = ($urandom_range(0, 7) == 0);
      send(s, inv, last, ref_mix(s, inv, last), w);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
